// File: rtl/fir_sequencer_if.sv
// Handshake bundle between the FIR front-end sequencer, its sample source/sink and the FIR core.
// The sequencer uses the slave view; the environment around it uses the master view.
interface fir_sequencer_if;
  logic signed [15:0] s_data;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] m_data;
  logic               m_valid;
  logic               m_ready;
  logic signed [15:0] fir_in;
  logic               fir_input_ready;
  logic               fir_output_ready;
  logic signed [15:0] fir_out;
  logic               fir_rst;
  logic               err;

  modport master (
    output s_data, s_valid, m_ready, fir_output_ready, fir_out,
    input  s_ready, m_data, m_valid, fir_in, fir_input_ready, fir_rst, err
  );

  modport slave (
    input  s_data, s_valid, m_ready, fir_output_ready, fir_out,
    output s_ready, m_data, m_valid, fir_in, fir_input_ready, fir_rst, err
  );
endinterface

// File: rtl/fir_sequencer.sv
// Buffers samples in a small FIFO, issues them one at a time to the 16-tap FIR, captures each
// result onto a valid/ready output, and resets the FIR through a watchdog if it stops answering.
module fir_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 32
) (
  input logic            ck,
  input logic            rst,
  fir_sequencer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StIssue, StBusy, StCapture, StHold} state_e;

  state_e             state_q;
  logic signed [15:0] mem_q [DEPTH];
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [CW-1:0]      count_q;
  logic [WW-1:0]      wd_q;
  logic signed [15:0] fir_in_q, m_data_q;
  logic               fir_ir_q, fir_rst_q, m_valid_q, err_q;

  logic full, empty, push, pop, cap_load, hold_load;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign push      = bus.s_valid && bus.s_ready;
  assign cap_load  = (state_q == StCapture) && (!m_valid_q || bus.m_ready);
  assign hold_load = (state_q == StHold) && bus.m_ready;
  // Popping straight out of CAPTURE/HOLD keeps issues 20 cycles apart under full throughput.
  assign pop       = !empty && ((state_q == StIdle) || cap_load || hold_load);

  assign bus.s_ready         = rst && !full;
  assign bus.m_data          = m_data_q;
  assign bus.m_valid         = m_valid_q;
  assign bus.fir_in          = fir_in_q;
  assign bus.fir_input_ready = fir_ir_q;
  assign bus.fir_rst         = fir_rst_q;
  assign bus.err             = err_q;

  always_ff @(posedge ck) begin
    if (!rst) begin
      state_q   <= StIdle;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      wd_q      <= '0;
      fir_in_q  <= '0;
      m_data_q  <= '0;
      fir_ir_q  <= 1'b0;
      fir_rst_q <= 1'b1;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= bus.s_data;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop) begin
        fir_in_q <= mem_q[rptr_q];
        rptr_q   <= rptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end

      fir_ir_q  <= 1'b0;
      fir_rst_q <= 1'b0;
      if (m_valid_q && bus.m_ready) begin
        m_valid_q <= 1'b0;
      end
      if (bus.fir_output_ready && (state_q != StBusy)) begin
        err_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (pop) begin
            fir_ir_q <= 1'b1;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          wd_q    <= '0;
          state_q <= StBusy;
        end
        StBusy: begin
          // A result arriving on the final watchdog cycle still wins.
          if (bus.fir_output_ready) begin
            state_q <= StCapture;
          end else if (wd_q == WW'(TIMEOUT - 1)) begin
            err_q     <= 1'b1;
            fir_rst_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            wd_q <= wd_q + WW'(1);
          end
        end
        StCapture, StHold: begin
          if (cap_load || hold_load) begin
            m_data_q  <= bus.fir_out;
            m_valid_q <= 1'b1;
            fir_ir_q  <= pop;
            state_q   <= pop ? StIssue : StIdle;
          end else begin
            state_q <= StHold;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer with a first-tap-only FIR stub (out = round(x*-81/32768))
// that follows the FIR's 19-cycle load/compute/output timing.
module tb_fir_sequencer;
  logic ck = 1'b0;
  logic rst = 1'b0;
  fir_sequencer_if bus ();

  fir_sequencer #(.DEPTH(4), .TIMEOUT(32)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  always #5 ck = ~ck;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stalls   = 0;
  logic signed [15:0] pend[$];
  int outs[$];
  int out_cyc[$];

  // FIR stub
  logic [4:0]         fcnt;
  logic signed [15:0] fx, model_out;
  logic               model_ordy;
  logic               spur_ordy = 1'b0;
  logic               stub_dead = 1'b0;

  assign bus.fir_output_ready = model_ordy | spur_ordy;
  assign bus.fir_out          = model_out;

  function automatic logic signed [15:0] first_tap(input logic signed [15:0] x);
    int p;
    p = int'(x) * -81 + 16384;
    return 16'(p >>> 15);
  endfunction

  always @(posedge ck or posedge bus.fir_rst) begin
    if (bus.fir_rst) begin
      fcnt       <= 5'd0;
      fx         <= '0;
      model_out  <= '0;
      model_ordy <= 1'b0;
    end else begin
      model_ordy <= 1'b0;
      case (fcnt)
        5'd0:    if (bus.fir_input_ready) fcnt <= 5'd1;
        5'd1:    begin fx <= bus.fir_in; fcnt <= 5'd2; end
        5'd17:   begin model_ordy <= !stub_dead; fcnt <= 5'd18; end
        5'd18:   begin model_out <= first_tap(fx); fcnt <= 5'd0; end
        default: fcnt <= fcnt + 5'd1;
      endcase
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge ck);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    spur_ordy = 1'b0;
    stub_dead = 1'b0;
    step(3);
    rst = 1'b1;
  endtask

  task automatic push_one(input logic signed [15:0] d);
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    step(1);
    bus.s_valid = 1'b0;
  endtask

  // Feeds pend while s_ready allows and logs every accepted output with its cycle.
  task automatic run(input int n);
    logic take;
    for (int c = 0; c < n; c++) begin
      bus.s_valid = (pend.size() > 0);
      if (pend.size() > 0) bus.s_data = pend[0];
      if (bus.s_valid && !bus.s_ready) stalls++;
      if (bus.m_valid && bus.m_ready) begin
        outs.push_back(int'(bus.m_data));
        out_cyc.push_back(cyc);
      end
      take = bus.s_valid && bus.s_ready;
      step(1);
      if (take) void'(pend.pop_front());
    end
    bus.s_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a;
    int exp_burst[6];
    exp_burst = '{-2, -5, -7, -10, -12, -15};
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;

    // Reset values
    rst = 1'b0;
    step(3);
    check_eq("rst_s_ready", int'(bus.s_ready), 0);
    check_eq("rst_m_valid", int'(bus.m_valid), 0);
    check_eq("rst_m_data", int'(bus.m_data), 0);
    check_eq("rst_fir_in", int'(bus.fir_in), 0);
    check_eq("rst_fir_ir", int'(bus.fir_input_ready), 0);
    check_eq("rst_fir_rst", int'(bus.fir_rst), 1);
    check_eq("rst_err", int'(bus.err), 0);
    rst = 1'b1;
    #1;
    check_eq("post_rst_s_ready", int'(bus.s_ready), 1);

    // Single sample: cycle A is the push cycle
    push_one(16'sd1000);
    check_eq("single_ir_a1", int'(bus.fir_input_ready), 0);
    step(1);
    check_eq("single_ir_a2", int'(bus.fir_input_ready), 1);
    check_eq("single_fir_in", int'(bus.fir_in), 1000);
    step(1);
    check_eq("single_ir_a3", int'(bus.fir_input_ready), 0);
    check_eq("single_fir_in_a3", int'(bus.fir_in), 1000);
    step(18);
    check_eq("single_mvalid_a21", int'(bus.m_valid), 0);
    step(1);
    check_eq("single_mvalid_a22", int'(bus.m_valid), 1);
    check_eq("single_mdata", int'(bus.m_data), -2);
    step(1);
    check_eq("single_mvalid_a23", int'(bus.m_valid), 0);
    step(2);

    // Burst of 6 through a 4-deep FIFO
    pend = '{16'sd1000, 16'sd2000, 16'sd3000, 16'sd4000, 16'sd5000, 16'sd6000};
    outs.delete();
    out_cyc.delete();
    stalls = 0;
    a = cyc;
    run(140);
    check_eq("burst_stalls", stalls, 17);
    check_eq("burst_count", outs.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < outs.size()) begin
        check_eq($sformatf("burst_data%0d", i), outs[i], exp_burst[i]);
        check_eq($sformatf("burst_cyc%0d", i), out_cyc[i] - a, 22 + 20 * i);
      end
    end

    // Backpressure: two results, second one parked in HOLD
    bus.m_ready = 1'b0;
    pend = '{16'sd7000, 16'sd8000};
    outs.delete();
    run(30);
    check_eq("bp_mvalid_30", int'(bus.m_valid), 1);
    check_eq("bp_mdata_30", int'(bus.m_data), -17);
    run(20);
    check_eq("bp_mvalid_50", int'(bus.m_valid), 1);
    check_eq("bp_mdata_50", int'(bus.m_data), -17);
    bus.m_ready = 1'b1;
    run(5);
    check_eq("bp_count", outs.size(), 2);
    if (outs.size() == 2) begin
      check_eq("bp_out0", outs[0], -17);
      check_eq("bp_out1", outs[1], -20);
    end
    check_eq("bp_mvalid_end", int'(bus.m_valid), 0);
    check_eq("bp_err", int'(bus.err), 0);

    // Spurious output strobe while idle
    spur_ordy = 1'b1;
    step(1);
    spur_ordy = 1'b0;
    check_eq("spur_err", int'(bus.err), 1);
    check_eq("spur_mvalid", int'(bus.m_valid), 0);
    push_one(16'sd2000);
    check_eq("spur_ir_a1", int'(bus.fir_input_ready), 0);
    step(1);
    check_eq("spur_ir_a2", int'(bus.fir_input_ready), 1);
    step(20);
    check_eq("spur_mvalid_a22", int'(bus.m_valid), 1);
    check_eq("spur_mdata", int'(bus.m_data), -5);

    // Watchdog: stub never answers the first sample
    do_reset();
    check_eq("wd_err_after_rst", int'(bus.err), 0);
    stub_dead = 1'b1;
    push_one(16'sd9000);
    push_one(16'sd1000);
    check_eq("wd_ir_a2", int'(bus.fir_input_ready), 1);
    step(20);
    check_eq("wd_err_a22", int'(bus.err), 0);
    check_eq("wd_mvalid_a22", int'(bus.m_valid), 0);
    step(12);
    check_eq("wd_err_a34", int'(bus.err), 0);
    check_eq("wd_fir_rst_a34", int'(bus.fir_rst), 0);
    step(1);
    check_eq("wd_err_a35", int'(bus.err), 1);
    check_eq("wd_fir_rst_a35", int'(bus.fir_rst), 1);
    check_eq("wd_mvalid_a35", int'(bus.m_valid), 0);
    stub_dead = 1'b0;
    step(1);
    check_eq("wd_fir_rst_a36", int'(bus.fir_rst), 0);
    check_eq("wd_ir_a36", int'(bus.fir_input_ready), 1);
    check_eq("wd_fir_in_a36", int'(bus.fir_in), 1000);
    step(19);
    check_eq("wd_mvalid_a55", int'(bus.m_valid), 0);
    step(1);
    check_eq("wd_mvalid_a56", int'(bus.m_valid), 1);
    check_eq("wd_mdata", int'(bus.m_data), -2);
    check_eq("wd_err_sticky", int'(bus.err), 1);

    // Reset in the middle of BUSY with samples still queued
    do_reset();
    push_one(16'sd3000);
    push_one(16'sd4000);
    push_one(16'sd5000);
    step(7);
    rst = 1'b0;
    step(1);
    check_eq("mid_rst_fir_rst", int'(bus.fir_rst), 1);
    check_eq("mid_rst_mvalid", int'(bus.m_valid), 0);
    check_eq("mid_rst_s_ready", int'(bus.s_ready), 0);
    check_eq("mid_rst_err", int'(bus.err), 0);
    step(1);
    rst = 1'b1;
    #1;
    check_eq("mid_post_s_ready", int'(bus.s_ready), 1);
    push_one(16'sd6000);
    check_eq("mid_ir_b1", int'(bus.fir_input_ready), 0);
    step(1);
    check_eq("mid_ir_b2", int'(bus.fir_input_ready), 1);
    check_eq("mid_fir_in_b2", int'(bus.fir_in), 6000);
    step(19);
    check_eq("mid_mvalid_b21", int'(bus.m_valid), 0);
    step(1);
    check_eq("mid_mvalid_b22", int'(bus.m_valid), 1);
    check_eq("mid_mdata", int'(bus.m_data), -15);
    step(1);
    outs.delete();
    run(40);
    check_eq("mid_no_stale_out", outs.size(), 0);
    check_eq("mid_err_end", int'(bus.err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
